// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control unit: instruction fields, opcodes,
// ALU opcodes and FSM state encoding.
package cpu_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned RD_MSB   = 11;
  localparam int unsigned RD_LSB   = 10;
  localparam int unsigned RS_MSB   = 9;
  localparam int unsigned RS_LSB   = 8;
  localparam int unsigned IMM_MSB  = 7;
  localparam int unsigned IMM_LSB  = 0;
  localparam int unsigned REG_AW   = 2;
  localparam int unsigned NUM_REGS = 4;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  // Arithmetic instruction opcodes coincide with the ALU opcodes they drive
  localparam logic [3:0] OP_ADD  = ALU_ADD;
  localparam logic [3:0] OP_SUB  = ALU_SUB;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_JZ   = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_OUT  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Bus bundle between the control unit and its ROM, ALU and board top level.
interface cpu_control_unit_if
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned DATA_W = 8
);
  logic               run;
  logic [PC_W-1:0]    rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               alu_enable;
  logic [3:0]         alu_opcode;
  logic [DATA_W-1:0]  alu_op1;
  logic [DATA_W-1:0]  alu_op2;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_zero;
  logic               alu_carry;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               halted;

  modport master (
    input  run, rom_data, alu_result, alu_zero, alu_carry,
    output rom_addr, alu_enable, alu_opcode, alu_op1, alu_op2,
           out_data, out_valid, halted
  );

  modport slave (
    output run, rom_data, alu_result, alu_zero, alu_carry,
    input  rom_addr, alu_enable, alu_opcode, alu_op1, alu_op2,
           out_data, out_valid, halted
  );
endinterface

// File: rtl/regfile_4x8.sv
// Four-entry register file: two asynchronous read ports, one synchronous
// write port, asynchronous clear.
module regfile_4x8
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/sequence controller feeding an 8-bit ALU: owns PC, IR, flags
// and the FSM; registers live in regfile_4x8.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  cpu_control_unit_if.master bus
);

  state_t             r_state, w_state_nxt;
  logic [PC_W-1:0]    r_pc, w_pc_nxt, w_pc_inc;
  logic [INSTR_W-1:0] r_ir, w_ir_nxt;
  logic               r_z, w_z_nxt;
  logic               r_c, w_c_nxt;
  logic [3:0]         r_alu_opcode, w_alu_opcode_nxt;
  logic [DATA_W-1:0]  r_alu_op1, w_alu_op1_nxt;
  logic [DATA_W-1:0]  r_alu_op2, w_alu_op2_nxt;
  logic               r_alu_enable, w_alu_enable_nxt;
  logic [DATA_W-1:0]  r_out_data, w_out_data_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic               r_halted, w_halted_nxt;

  logic [3:0]         w_op;
  logic [REG_AW-1:0]  w_rd, w_rs;
  logic [7:0]         w_imm;
  logic [DATA_W-1:0]  w_rd_data, w_rs_data;
  logic               w_rf_we;
  logic [DATA_W-1:0]  w_rf_wdata;

  assign w_op     = r_ir[OP_MSB:OP_LSB];
  assign w_rd     = r_ir[RD_MSB:RD_LSB];
  assign w_rs     = r_ir[RS_MSB:RS_LSB];
  assign w_imm    = r_ir[IMM_MSB:IMM_LSB];
  assign w_pc_inc = r_pc + PC_W'(1);

  regfile_4x8 #(.DATA_W(DATA_W)) u_regfile (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_raddr_a (w_rd),
    .o_rdata_a (w_rd_data),
    .i_raddr_b (w_rs),
    .o_rdata_b (w_rs_data),
    .i_we      (w_rf_we),
    .i_waddr   (w_rd),
    .i_wdata   (w_rf_wdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= '0;
      r_ir         <= '0;
      r_z          <= 1'b0;
      r_c          <= 1'b0;
      r_alu_opcode <= '0;
      r_alu_op1    <= '0;
      r_alu_op2    <= '0;
      r_alu_enable <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_ir         <= w_ir_nxt;
      r_z          <= w_z_nxt;
      r_c          <= w_c_nxt;
      r_alu_opcode <= w_alu_opcode_nxt;
      r_alu_op1    <= w_alu_op1_nxt;
      r_alu_op2    <= w_alu_op2_nxt;
      r_alu_enable <= w_alu_enable_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_halted     <= w_halted_nxt;
    end
  end

  // Next-state and next-value logic; pulses (enable, valid) default low
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ir_nxt         = r_ir;
    w_z_nxt          = r_z;
    w_c_nxt          = r_c;
    w_alu_opcode_nxt = r_alu_opcode;
    w_alu_op1_nxt    = r_alu_op1;
    w_alu_op2_nxt    = r_alu_op2;
    w_alu_enable_nxt = 1'b0;
    w_out_data_nxt   = r_out_data;
    w_out_valid_nxt  = 1'b0;
    w_halted_nxt     = 1'b0;
    w_rf_we          = 1'b0;
    w_rf_wdata       = DATA_W'(w_imm);

    case (r_state)
      ST_FETCH: begin
        if (bus.run) begin
          w_ir_nxt    = bus.rom_data;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_alu_opcode_nxt = w_op;
        w_alu_op1_nxt    = w_rd_data;
        w_alu_op2_nxt    = w_rs_data;
        w_alu_enable_nxt = is_alu_op(w_op);
        w_state_nxt      = ST_EXEC;
      end
      ST_EXEC: begin
        w_state_nxt = ST_FETCH;
        case (w_op)
          OP_ADD, OP_SUB: w_state_nxt = ST_WB;
          OP_LDI: begin
            w_rf_we  = 1'b1;
            w_pc_nxt = w_pc_inc;
          end
          OP_JZ:  w_pc_nxt = r_z ? PC_W'(w_imm) : w_pc_inc;
          OP_JMP: w_pc_nxt = PC_W'(w_imm);
          OP_OUT: begin
            w_out_data_nxt  = w_rd_data;
            w_out_valid_nxt = 1'b1;
            w_pc_nxt        = w_pc_inc;
          end
          OP_HALT: begin
            w_state_nxt  = ST_HALT;
            w_halted_nxt = 1'b1;
          end
          default: w_pc_nxt = w_pc_inc;
        endcase
      end
      ST_WB: begin
        w_rf_we     = 1'b1;
        w_rf_wdata  = bus.alu_result;
        w_z_nxt     = bus.alu_zero;
        w_c_nxt     = bus.alu_carry;
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = ST_FETCH;
      end
      ST_HALT: w_halted_nxt = 1'b1;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  assign bus.rom_addr   = r_pc;
  assign bus.alu_enable = r_alu_enable;
  assign bus.alu_opcode = r_alu_opcode;
  assign bus.alu_op1    = r_alu_op1;
  assign bus.alu_op2    = r_alu_op2;
  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.halted     = r_halted;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: behavioural ROM and ALU, expected
// OUT values queued per program and compared on each out_valid pulse.
module tb_cpu_control_unit;
  import cpu_pkg::*;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned DATA_W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   en_cnt = 0;
  logic prev_en = 1'b0;
  logic [PC_W-1:0]   prev_addr = '0;
  logic [15:0]       rom [256];
  logic [DATA_W-1:0] sb [$];
  logic [8:0]        alu_calc;

  cpu_control_unit_if #(.PC_W(PC_W), .DATA_W(DATA_W)) u_if ();

  cpu_control_unit #(.PC_W(PC_W), .DATA_W(DATA_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.master)
  );

  always #5 clk = ~clk;

  assign u_if.rom_data = rom[u_if.rom_addr];

  // Behavioural ALU: registers result and flags on a rising edge with enable
  always_comb begin
    if (u_if.alu_opcode == ALU_SUB) alu_calc = {1'b0, u_if.alu_op1} - {1'b0, u_if.alu_op2};
    else                            alu_calc = {1'b0, u_if.alu_op1} + {1'b0, u_if.alu_op2};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u_if.alu_result <= '0;
      u_if.alu_zero   <= 1'b0;
      u_if.alu_carry  <= 1'b0;
    end else if (u_if.alu_enable) begin
      u_if.alu_result <= alu_calc[7:0];
      u_if.alu_zero   <= (alu_calc[7:0] == 8'h00);
      u_if.alu_carry  <= alu_calc[8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Output-side monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (u_if.alu_enable) begin
        en_cnt++;
        check("en_width", 32'(prev_en), 32'd0);
      end
      if (u_if.out_valid) begin
        if (sb.size() == 0) check("out_extra", 32'(sb.size()), 32'd1);
        else                check("out_data", 32'(u_if.out_data), 32'(sb.pop_front()));
      end
      if (prev_addr == 8'hFF && u_if.rom_addr != 8'hFF)
        check("pc_wrap", 32'(u_if.rom_addr), 32'd0);
    end
    prev_en   = u_if.alu_enable;
    prev_addr = u_if.rom_addr;
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = enc(OP_HALT, 2'd0, 2'd0, 8'h00);
  endtask

  task automatic do_reset(input logic run_v);
    @(negedge clk);
    reset    = 1'b1;
    u_if.run = run_v;
    sb.delete();
    en_cnt   = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until_halt(input string tag, input int exp_cyc);
    int n = 0;
    while (!u_if.halted && n < 400) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n), 32'(exp_cyc));
    check({tag, "_sb"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    logic any_seen;
    u_if.run = 1'b0;
    clear_rom();

    // Reset values
    @(negedge clk);
    check("rst_addr", 32'(u_if.rom_addr), 32'd0);
    check("rst_en", 32'(u_if.alu_enable), 32'd0);
    check("rst_halt", 32'(u_if.halted), 32'd0);
    check("rst_ov", 32'(u_if.out_valid), 32'd0);
    check("rst_od", 32'(u_if.out_data), 32'd0);

    // LDI then OUT then HALT
    clear_rom();
    rom[0] = enc(OP_LDI, 2'd0, 2'd0, 8'h5A);
    rom[1] = enc(OP_OUT, 2'd0, 2'd0, 8'h00);
    do_reset(1'b1);
    sb.push_back(8'h5A);
    run_until_halt("t1_cyc", 9);

    // ADD with carry out
    clear_rom();
    rom[0] = enc(OP_LDI, 2'd1, 2'd0, 8'hF0);
    rom[1] = enc(OP_LDI, 2'd2, 2'd0, 8'h20);
    rom[2] = enc(OP_ADD, 2'd1, 2'd2, 8'h00);
    rom[3] = enc(OP_OUT, 2'd1, 2'd0, 8'h00);
    do_reset(1'b1);
    sb.push_back(8'h10);
    run_until_halt("t2_cyc", 16);
    check("t2_en_cnt", 32'(en_cnt), 32'd1);

    // SUB equal operands then JZ taken
    clear_rom();
    rom[0]    = enc(OP_LDI, 2'd3, 2'd0, 8'h07);
    rom[1]    = enc(OP_SUB, 2'd3, 2'd3, 8'h00);
    rom[2]    = enc(OP_JZ,  2'd0, 2'd0, 8'h10);
    rom[3]    = enc(OP_LDI, 2'd3, 2'd0, 8'hEE);
    rom[4]    = enc(OP_OUT, 2'd3, 2'd0, 8'h00);
    rom[8'h10] = enc(OP_OUT, 2'd3, 2'd0, 8'h00);
    do_reset(1'b1);
    sb.push_back(8'h00);
    run_until_halt("t3a_cyc", 16);

    // SUB unequal operands then JZ falls through
    clear_rom();
    rom[0]    = enc(OP_LDI, 2'd3, 2'd0, 8'h07);
    rom[1]    = enc(OP_LDI, 2'd2, 2'd0, 8'h03);
    rom[2]    = enc(OP_SUB, 2'd3, 2'd2, 8'h00);
    rom[3]    = enc(OP_JZ,  2'd0, 2'd0, 8'h10);
    rom[4]    = enc(OP_OUT, 2'd3, 2'd0, 8'h00);
    rom[8'h10] = enc(OP_OUT, 2'd2, 2'd0, 8'h00);
    do_reset(1'b1);
    sb.push_back(8'h04);
    run_until_halt("t3b_cyc", 19);

    // PC wraps from 0xFF to 0x00
    clear_rom();
    rom[0]     = enc(OP_JZ,  2'd0, 2'd0, 8'h10);
    rom[1]     = enc(OP_LDI, 2'd0, 2'd0, 8'h01);
    rom[2]     = enc(OP_SUB, 2'd0, 2'd0, 8'h00);
    rom[3]     = enc(OP_JMP, 2'd0, 2'd0, 8'hFF);
    rom[8'hFF] = enc(4'h6,   2'd0, 2'd0, 8'h00);
    rom[8'h10] = enc(OP_LDI, 2'd1, 2'd0, 8'hAB);
    rom[8'h11] = enc(OP_OUT, 2'd1, 2'd0, 8'h00);
    do_reset(1'b1);
    sb.push_back(8'hAB);
    run_until_halt("t4_cyc", 28);

    // run held low after reset, then dropped during an ADD
    clear_rom();
    rom[0] = enc(OP_LDI, 2'd1, 2'd0, 8'h01);
    rom[1] = enc(OP_LDI, 2'd2, 2'd0, 8'h02);
    rom[2] = enc(OP_ADD, 2'd1, 2'd2, 8'h00);
    rom[3] = enc(OP_OUT, 2'd1, 2'd0, 8'h00);
    do_reset(1'b0);
    sb.push_back(8'h03);
    any_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_seen = any_seen | (|u_if.rom_addr) | u_if.out_valid | u_if.alu_enable
                 | u_if.halted | (|u_if.out_data);
    end
    check("t5_idle_addr", 32'(u_if.rom_addr), 32'd0);
    check("t5_idle_quiet", 32'(any_seen), 32'd0);
    u_if.run = 1'b1;
    n = 0;
    while (!u_if.alu_enable && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_en_seen", 32'(u_if.alu_enable), 32'd1);
    u_if.run = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_stall_addr", 32'(u_if.rom_addr), 32'd3);
    check("t5_stall_halt", 32'(u_if.halted), 32'd0);
    u_if.run = 1'b1;
    run_until_halt("t5_cyc", 6);

    // Reset asserted while alu_enable is high
    clear_rom();
    rom[0] = enc(OP_LDI, 2'd1, 2'd0, 8'h05);
    rom[1] = enc(OP_LDI, 2'd2, 2'd0, 8'h06);
    rom[2] = enc(OP_ADD, 2'd1, 2'd2, 8'h00);
    do_reset(1'b1);
    n = 0;
    while (!u_if.alu_enable && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_en_seen", 32'(u_if.alu_enable), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_en_drop", 32'(u_if.alu_enable), 32'd0);
    check("t6_addr", 32'(u_if.rom_addr), 32'd0);
    check("t6_halt", 32'(u_if.halted), 32'd0);
    check("t6_op1", 32'(u_if.alu_op1), 32'd0);
    clear_rom();
    rom[0] = enc(OP_OUT, 2'd1, 2'd0, 8'h00);
    rom[1] = enc(OP_OUT, 2'd2, 2'd0, 8'h00);
    do_reset(1'b1);
    sb.push_back(8'h00);
    sb.push_back(8'h00);
    run_until_halt("t6_cyc", 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Fetch/decode/sequence controller that sits directly upstream of the 8-bit ALU. Fetches 16-bit instructions from an asynchronous program ROM, holds a 4×8 register file and program counter, and drives the ALU's opcode, operand and enable inputs. Captures the ALU's result and flags on writeback. Also provides a simple output port and a halt indication for the board top level.

## Interface
Parameters:
- `PC_W`, default 8: program counter and ROM address width.
- `DATA_W`, default 8: register, operand and output width; must match the ALU.

Ports:
- `clk`, in, 1: system clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset, shared with the ALU.
- `run`, in, 1: level signal; when low, the FSM waits in FETCH.
- `rom_addr`, out, `PC_W`: equals PC.
- `rom_data`, in, 16: instruction word, combinational from ROM.
- `alu_enable`, out, 1: the ALU evaluates on its rising edge.
- `alu_opcode`, out, 4: ALU opcode; 0000 = ADD, 0001 = SUB.
- `alu_op1`, `alu_op2`, out, `DATA_W`: ALU operands.
- `alu_result`, in, `DATA_W`; `alu_zero`, in, 1; `alu_carry`, in, 1: ALU outputs.
- `out_data`, out, `DATA_W`; `out_valid`, out, 1: output port.
- `halted`, out, 1: high while the FSM is in the HALT state.

## Operation
- **Instruction format:** [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
- **Ops:**
  - 0 ADD: rd = rd + rs.
  - 1 SUB: rd = rd − rs.
  - 2 LDI: rd = imm.
  - 3 JZ: if Z then PC = imm, else PC + 1.
  - 4 JMP: PC = imm.
  - 5 OUT: out_data = rd.
  - F HALT.
  - 6–E: NOP.
- **States:** FETCH → DECODE → EXEC → (WB for ADD/SUB only) → FETCH. HALT is absorbing.
- **FETCH:** if `run` = 1, IR ← `rom_data`, go to DECODE. Otherwise hold; PC and IR are unchanged.
- **DECODE:** register `alu_opcode` ← op[3:0], `alu_op1` ← R[rd], `alu_op2` ← R[rs]. These registers update in DECODE only, so they stay stable through EXEC and WB.
- **EXEC:**
  - ADD/SUB: `alu_enable` = 1; go to WB.
  - LDI: R[rd] ← imm, PC + 1.
  - JZ/JMP: PC ← target per the rules above.
  - OUT: `out_data` ← R[rd], `out_valid` pulse, PC + 1.
  - NOP: PC + 1.
  - HALT: go to HALT; PC unchanged.
  - All non-ADD/SUB ops return to FETCH (except HALT).
- **WB:** R[rd] ← `alu_result`; Z ← `alu_zero`; C ← `alu_carry`; PC + 1.
- **Flags:** Z/C are internal registers, written only by ADD/SUB.
- **PC arithmetic:** modulo 2^`PC_W`; 255 + 1 wraps to 0. A jump to the current address is legal (tight loop).
- **Register hazards:** rd = rs is legal. SUB R1,R1 gives 0, Z = 1, and R1 ends at 0.
- **Reset values:** PC = 0; IR = 0; R0–R3 = 0; Z = C = 0; state = FETCH. All outputs = 0 (`halted` = 0, `alu_enable` = 0).

## Timing
- **`alu_enable`:** registered; high for exactly one `clk` cycle, the EXEC cycle of ADD/SUB. Low in every other state.
  - Its rising edge comes one cycle after the operands were registered, so operands are stable ≥ 1 cycle before the ALU samples.
- **WB sampling:** WB samples `alu_result`/flags one full cycle after the `alu_enable` rise.
- **Latency:** ADD/SUB take 4 cycles per instruction. All other ops take 3 cycles; HALT enters its state after 3.
- **`out_valid`:**
  - Registered; high for exactly the one cycle following OUT's EXEC.
  - `out_data` changes only together with the `out_valid` pulse and holds between OUTs.
- **`run`:** sampled only in FETCH. Deasserting `run` mid-instruction lets the instruction complete, then the FSM stalls in the next FETCH.
- **`halted`:** goes to 1 on the edge leaving HALT's EXEC. Only `reset` exits HALT; `run` is ignored there.
- **Reset mid-instruction:**
  - Asynchronous; `alu_enable` drops immediately and all state returns to its reset value.
  - No writeback occurs. The ALU resets concurrently.
  - After release, the first fetch is at address 0 on the first `clk` edge with `run` = 1.

## Structure
- **Shared package `cpu_pkg`:**
  - Instruction opcode constants.
  - ALU opcode constants (ADD = 4'b0000, SUB = 4'b0001), shared with the ALU.
  - FSM state encoding (FETCH, DECODE, EXEC, WB, HALT).
  - Instruction field positions.
- **Sub-module `regfile_4x8`:** two asynchronous read ports, one synchronous write port, asynchronous reset to zero.
- **FSM, PC, IR and flags:** remain in `cpu_control_unit`.

## Test plan
- **LDI then OUT:** ROM = LDI R0,0x5A; OUT R0; HALT. Expect `out_valid` for 1 cycle with `out_data` = 0x5A, then `halted` = 1 after 9 cycles total (3 instructions × 3 cycles).
- **ADD with carry:** R1 = 0xF0, R2 = 0x20, ADD R1,R2. Expect `alu_enable` high for exactly 1 cycle, R1 = 0x10, C = 1. Check via OUT R1 → 0x10.
- **SUB and JZ:** R3 = 7, SUB R3,R3, JZ 0x10. Expect Z = 1 and the next `rom_addr` = 0x10. Repeat with unequal operands: PC falls through to +1.
- **PC wrap:** JMP 0xFF; the NOP at 0xFF is followed by a fetch at `rom_addr` = 0x00.
- **`run` stall:** hold `run` = 0 after reset for 10 cycles. `rom_addr` stays 0, no outputs toggle. Drop `run` during an ADD: the ADD completes, then the FSM stalls in FETCH at PC + 1.
- **Reset mid-EXEC of ADD:** assert `reset` while `alu_enable` = 1. `alu_enable` = 0 immediately, registers = 0, PC = 0, `halted` = 0.
